// File: rtl/screen_sequencer.sv
// -----------------------------------------------------------------------------
// screen_sequencer
//
// Page sequencer for a four-page display (START, PRACTICE, ESCAPE, RESULT).
// Button/level events raise a pending page request (busy=1); the request is
// committed only on a frame_tick so the display page mux switches during
// vertical blank. While busy, only btn_back is honoured: it retargets the
// pending request to START.
//
// ESCAPE runs a seconds countdown (frame_tick based) that forces RESULT with
// win=0 when it expires. RESULT returns to START by itself after
// RESULT_FRAMES frames.
//
// Optional feature macro: SCREEN_SEQ_TIMER_EN
//   defined   -> ESCAPE countdown and timeout active
//   undefined -> time_left is constant 0, ESCAPE leaves only on done/fail/back
//
// Parameters:
//   FRAMES_PER_SEC  frame_ticks per countdown second (2..255)
//   ESCAPE_SECONDS  countdown start value on ESCAPE entry (1..255)
//   RESULT_FRAMES   frames RESULT is shown before auto-return (1..255)
//
// Ports:
//   clk           pixel-domain clock, rising edge
//   reset         asynchronous active-high reset
//   frame_tick    one-cycle pulse at start of vertical blank
//   btn_dot       "." key pulse
//   btn_dash      "-" key pulse
//   btn_back      return-to-start key pulse
//   level_done    escape level solved pulse
//   level_fail    escape level failed pulse
//   page_sel      committed page (0 START, 1 PRACTICE, 2 ESCAPE, 3 RESULT)
//   page_changed  one-cycle pulse the cycle after a commit
//   busy          a page change is pending
//   win           result outcome, 1 = escaped
//   time_left     escape seconds remaining
//
// Handshake: events are single-cycle pulses with no back-pressure; an event
// seen while busy=0 is accepted in that cycle, events while busy=1 are
// dropped (except btn_back, which retargets the pending request).
// -----------------------------------------------------------------------------
module screen_sequencer #(
  parameter int FRAMES_PER_SEC = 60,
  parameter int ESCAPE_SECONDS = 90,
  parameter int RESULT_FRAMES  = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_dot,
  input  logic       btn_dash,
  input  logic       btn_back,
  input  logic       level_done,
  input  logic       level_fail,
  output logic [1:0] page_sel,
  output logic       page_changed,
  output logic       busy,
  output logic       win,
  output logic [7:0] time_left
);

  generate
    if (FRAMES_PER_SEC < 2 || FRAMES_PER_SEC > 255 ||
        ESCAPE_SECONDS < 1 || ESCAPE_SECONDS > 255 ||
        RESULT_FRAMES  < 1 || RESULT_FRAMES  > 255) begin : g_bad_param
      $error("screen_sequencer: parameter out of range");
    end
  endgenerate

  typedef enum logic [1:0] {
    PG_START    = 2'd0,
    PG_PRACTICE = 2'd1,
    PG_ESCAPE   = 2'd2,
    PG_RESULT   = 2'd3
  } page_t;

  // Sequencer state
  page_t page_q, page_d;
  logic  busy_q, busy_d;
  page_t pend_page_q, pend_page_d;
  logic  pend_win_q, pend_win_d;
  logic  win_q, win_d;
  logic  changed_q, changed_d;

  // Event selection / commit signals
  logic  ev_valid;
  page_t ev_page;
  logic  ev_win;
  page_t eff_page;   // pending target after a possible btn_back override
  logic  eff_win;
  logic  commit;

  // Result page frame counter
  logic [7:0] result_q;
  logic       result_step;
  logic       auto_req;

  logic       timeout_req;

  assign result_step = (page_q == PG_RESULT) && !busy_q && frame_tick;
  assign auto_req    = result_step && (result_q == 8'(RESULT_FRAMES - 1));

`ifdef SCREEN_SEQ_TIMER_EN
  logic [7:0] frame_q;
  logic [7:0] time_q;
  logic       timer_step;
  logic       frame_wrap;

  assign timer_step  = (page_q == PG_ESCAPE) && !busy_q && frame_tick;
  assign frame_wrap  = (frame_q == 8'(FRAMES_PER_SEC - 1));
  // Raised on the tick that takes time_left from 1 to 0.
  assign timeout_req = timer_step && frame_wrap && (time_q == 8'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_q <= 8'd0;
      time_q  <= 8'd0;
    end else if (commit && eff_page == PG_ESCAPE) begin
      frame_q <= 8'd0;
      time_q  <= 8'(ESCAPE_SECONDS);
    end else if (timer_step) begin
      if (frame_wrap) begin
        frame_q <= 8'd0;
        time_q  <= (time_q == 8'd0) ? 8'd0 : time_q - 8'd1;
      end else begin
        frame_q <= frame_q + 8'd1;
      end
    end
  end

  assign time_left = time_q;
`else
  assign timeout_req = 1'b0;
  assign time_left   = 8'd0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= 8'd0;
    end else if (commit && eff_page == PG_RESULT) begin
      result_q <= 8'd0;
    end else if (result_step) begin
      result_q <= auto_req ? 8'd0 : result_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      page_q      <= PG_START;
      busy_q      <= 1'b0;
      pend_page_q <= PG_START;
      pend_win_q  <= 1'b0;
      win_q       <= 1'b0;
      changed_q   <= 1'b0;
    end else begin
      page_q      <= page_d;
      busy_q      <= busy_d;
      pend_page_q <= pend_page_d;
      pend_win_q  <= pend_win_d;
      win_q       <= win_d;
      changed_q   <= changed_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // Highest-priority event that is legal on the committed page.
  always_comb begin
    ev_valid = 1'b0;
    ev_page  = PG_START;
    ev_win   = 1'b0;
    unique case (page_q)
      PG_START: begin
        if (btn_dot) begin
          ev_valid = 1'b1;
          ev_page  = PG_PRACTICE;
        end else if (btn_dash) begin
          ev_valid = 1'b1;
          ev_page  = PG_ESCAPE;
        end
      end
      PG_PRACTICE: begin
        if (btn_back) ev_valid = 1'b1;
      end
      PG_ESCAPE: begin
        if (btn_back) begin
          ev_valid = 1'b1;
        end else if (level_fail) begin
          ev_valid = 1'b1;
          ev_page  = PG_RESULT;
        end else if (level_done) begin
          ev_valid = 1'b1;
          ev_page  = PG_RESULT;
          ev_win   = 1'b1;
        end else if (timeout_req) begin
          ev_valid = 1'b1;
          ev_page  = PG_RESULT;
        end
      end
      PG_RESULT: begin
        if (btn_back || btn_dot || btn_dash || auto_req) ev_valid = 1'b1;
      end
      default: ev_valid = 1'b0;
    endcase
  end

  always_comb begin
    eff_page = btn_back ? PG_START : pend_page_q;
    eff_win  = btn_back ? 1'b0     : pend_win_q;
    commit   = busy_q && frame_tick;
  end

  always_comb begin
    page_d      = page_q;
    busy_d      = busy_q;
    pend_page_d = pend_page_q;
    pend_win_d  = pend_win_q;
    win_d       = win_q;
    changed_d   = 1'b0;
    if (busy_q) begin
      pend_page_d = eff_page;
      pend_win_d  = eff_win;
      if (commit) begin
        page_d    = eff_page;
        win_d     = eff_win;   // always 0 when the target is START
        busy_d    = 1'b0;
        changed_d = 1'b1;
      end
    end else if (ev_valid) begin
      // Accepted even on a frame_tick cycle; commit waits for the next tick.
      busy_d      = 1'b1;
      pend_page_d = ev_page;
      pend_win_d  = ev_win;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    page_sel     = page_q;
    busy         = busy_q;
    win          = win_q;
    page_changed = changed_q;
  end

endmodule

// File: doc/screen_sequencer.md
SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

Interface
REQ-001 Parameter FRAMES_PER_SEC, default 60, frame_tick pulses per countdown second (2..255).
REQ-002 Parameter ESCAPE_SECONDS, default 90, escape-mode countdown start value (1..255).
REQ-003 Parameter RESULT_FRAMES, default 180, frames the result page is shown before automatic return (1..255).
REQ-004 clk  input  1  system pixel-domain clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 frame_tick  input  1  one-cycle pulse at start of vertical blank.
REQ-007 btn_dot  input  1  one-cycle pulse, debounced "." key.
REQ-008 btn_dash  input  1  one-cycle pulse, debounced "-" key.
REQ-009 btn_back  input  1  one-cycle pulse, return-to-start key.
REQ-010 level_done  input  1  one-cycle pulse, escape level solved.
REQ-011 level_fail  input  1  one-cycle pulse, escape level failed.
REQ-012 page_sel  output  2  committed page: 0 START, 1 PRACTICE, 2 ESCAPE, 3 RESULT; drives display page mux.
REQ-013 page_changed  output  1  one-cycle pulse the cycle after a commit.
REQ-014 busy  output  1  high while a page change is pending.
REQ-015 win  output  1  result outcome, 1 = escaped.
REQ-016 time_left  output  8  escape seconds remaining.

Function
REQ-017 Transitions SHALL be: START: dot->PRACTICE, dash->ESCAPE; PRACTICE: back->START, done/fail ignored; ESCAPE: done->RESULT win=1, fail->RESULT win=0, timeout->RESULT win=0, back->START; RESULT: dot/dash/back->START, auto-return->START.
REQ-018 Same-cycle input priority SHALL be back > level_fail > level_done > dot > dash > internal timeout/auto-return.
REQ-019 A valid event SHALL set busy and store the target page and win value as a pending request, evaluated against committed page_sel.
REQ-020 While busy, all new events SHALL be ignored except btn_back, which overwrites the pending target with START (win target 0).
REQ-021 Commit SHALL occur only on a cycle with frame_tick=1 and busy=1: page_sel and win update at that edge, busy clears, page_changed is high the following cycle only.
REQ-022 An event arriving in the same cycle as frame_tick while not busy SHALL be captured and committed on the next frame_tick, never the current one.
REQ-023 On commit to ESCAPE, time_left SHALL load ESCAPE_SECONDS and the frame counter SHALL clear to 0.
REQ-024 In ESCAPE with busy=0, each frame_tick SHALL increment the frame counter; at FRAMES_PER_SEC-1 it wraps to 0 and time_left decrements by 1.
REQ-025 When time_left becomes 0, an internal timeout request (RESULT, win=0) SHALL be raised; time_left SHALL saturate at 0 and never wrap.
REQ-026 Frame and result counters SHALL freeze while busy=1.
REQ-027 On commit to RESULT, the result counter SHALL clear; each frame_tick in RESULT with busy=0 increments it, and the tick at which it equals RESULT_FRAMES-1 SHALL raise a START request.
REQ-028 win SHALL clear on commit to START and hold otherwise; time_left SHALL hold its last value outside ESCAPE until the next ESCAPE entry.

Reset
REQ-029 Reset SHALL asynchronously force page_sel=0, busy=0, page_changed=0, win=0, time_left=0, all counters and pending state to 0.
REQ-030 Reset asserted mid-countdown or with a pending request SHALL discard it; first commit after release requires a new event plus frame_tick.

Configuration
REQ-031 Macro SCREEN_SEQ_TIMER_EN: defined -> REQ-023..025 countdown and timeout active; undefined -> time_left constant 0, no timeout, ESCAPE exits only on done/fail/back.

Verification
REQ-032 Params 2/3/4; reset, dot, frame_tick -> page_sel 0->1 at tick edge, page_changed one cycle, busy 1 only between event and tick.
REQ-033 From START, dash and frame_tick same cycle -> page_sel stays 0; next frame_tick -> page_sel=2, time_left=3.
REQ-034 ESCAPE with timer enabled, no input: 6 frame_ticks -> time_left 3,2,1,0; next tick -> page_sel=3, win=0; 4 more ticks -> request, next tick -> page_sel=0.
REQ-035 ESCAPE: level_done and btn_back same cycle -> pending START; tick -> page_sel=0, win=0; separately level_done alone -> page_sel=3, win=1.
REQ-036 Pending RESULT, then btn_back before tick -> commit to START; dot while pending -> ignored.
REQ-037 Reset during ESCAPE with time_left=2 and busy=1 -> all outputs 0 immediately; frame_tick after release -> no commit; timer-disabled build: time_left 0, no timeout after 20 ticks.
